// File: rtl/conv_ctrl_pkg.sv
// Shared types and sizing helpers for the convolution scheduler.
// Contents:
//   conv_state_e  scheduler FSM states
//   cnt_width     counter width for a modulus n (at least 1 bit)
//   scan_size     side of the scanned frame, IFM plus padding on both borders
//   ofm_size      number of window positions along one axis
package conv_ctrl_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StRun,
    StRowEnd,
    StChEnd,
    StFltEnd,
    StDrain,
    StDone
  } conv_state_e;

  function automatic int unsigned cnt_width(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  function automatic int unsigned scan_size(input int unsigned ifm, input int unsigned pad_eff);
    return ifm + 2 * pad_eff;
  endfunction

  function automatic int unsigned ofm_size(input int unsigned s, input int unsigned k,
                                           input int unsigned stride);
    return (s - k) / stride + 1;
  endfunction

endpackage

// File: rtl/conv_out_pipe.sv
// MAC-latency delay line for the output write descriptor.
// The pipe never stalls: it models the fixed MAC result latency.
// Ports:
//   clk1   clock
//   rst_n  async active-low reset, clears every stage
//   d_i    descriptor {acc_last, out_x, out_y, out_c} entering the MAC
//   q_o    same descriptor Depth cycles later
module conv_out_pipe #(
  parameter int unsigned Depth = 2,
  parameter int unsigned Width = 1
) (
  input  logic             clk1,
  input  logic             rst_n,
  input  logic [Width-1:0] d_i,
  output logic [Width-1:0] q_o
);

  logic [Width-1:0] stage_q [Depth];

  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < Depth; i++) stage_q[i] <= '0;
    end else begin
      stage_q[0] <= d_i;
      for (int i = 1; i < Depth; i++) stage_q[i] <= stage_q[i-1];
    end
  end

  assign q_o = stage_q[Depth-1];

endmodule

// File: rtl/conv_sched_ctrl.sv
// Convolution scheduler: scans the (optionally padded) input frame once per input channel and
// per output filter, driving the K-row line buffer, the MAC array and the OFM write descriptor.
// Optional feature: define CONV_PAD_EN to scan a frame padded by PAD pixels on every border;
// without it PAD has no effect and pad_zero_o stays 0.
// Ports:
//   clk1, rst_n      clock, async active-low reset
//   start_i          begin a layer (only accepted while idle)
//   stall_i          input pixel unavailable, freezes the scan in RUN
//   busy_o, done_o   layer in progress / one-cycle completion pulse
//   wr_en_o          one-hot line-buffer row write (row slot = y % K)
//   rd_en_o          all ones when the window is valid
//   mac_en_o         window valid
//   acc_clr_o        first channel of a window, acc_last_o last channel
//   pad_zero_o       accepted pixel lies in the pad border
//   out_valid_o      acc_last delayed by MAC_LAT, with out_x_o/out_y_o/out_c_o
module conv_sched_ctrl
  import conv_ctrl_pkg::*;
#(
  parameter int unsigned KERNEL_SIZE = 3,
  parameter int unsigned IFM_SIZE    = 9,
  parameter int unsigned CI          = 3,
  parameter int unsigned CO          = 4,
  parameter int unsigned STRIDE      = 1,
  parameter int unsigned PAD         = 1,
  parameter int unsigned MAC_LAT     = 2,
`ifdef CONV_PAD_EN
  localparam int unsigned PadEff     = PAD,
`else
  // PAD has no effect without padding support.
  localparam int unsigned PadEff     = 0 * PAD,
`endif
  localparam int unsigned ScanSize   = scan_size(IFM_SIZE, PadEff),
  localparam int unsigned OfmSize    = ofm_size(ScanSize, KERNEL_SIZE, STRIDE),
  localparam int unsigned OutW       = cnt_width(OfmSize),
  localparam int unsigned ChW        = cnt_width(CO)
) (
  input  logic                   clk1,
  input  logic                   rst_n,
  input  logic                   start_i,
  input  logic                   stall_i,
  output logic                   busy_o,
  output logic                   done_o,
  output logic [KERNEL_SIZE-1:0] wr_en_o,
  output logic [KERNEL_SIZE-1:0] rd_en_o,
  output logic                   mac_en_o,
  output logic                   acc_clr_o,
  output logic                   acc_last_o,
  output logic                   pad_zero_o,
  output logic                   out_valid_o,
  output logic [OutW-1:0]        out_x_o,
  output logic [OutW-1:0]        out_y_o,
  output logic [ChW-1:0]         out_c_o
);

  localparam int unsigned XW    = cnt_width(ScanSize);
  localparam int unsigned PhW   = cnt_width(STRIDE);
  localparam int unsigned CiW   = cnt_width(CI);
  localparam int unsigned LatW  = cnt_width(MAC_LAT);
  localparam int unsigned SlotW = cnt_width(KERNEL_SIZE);
  localparam int unsigned PipeW = 1 + 2 * OutW + ChW;

  localparam logic [XW-1:0]    ScanLast = XW'(ScanSize - 1);
  localparam logic [XW-1:0]    KLast    = XW'(KERNEL_SIZE - 1);
  localparam logic [PhW-1:0]   PhLast   = PhW'(STRIDE - 1);
  localparam logic [CiW-1:0]   CiLast   = CiW'(CI - 1);
  localparam logic [ChW-1:0]   CoLast   = ChW'(CO - 1);
  localparam logic [LatW-1:0]  LatLast  = LatW'(MAC_LAT - 1);
  localparam logic [SlotW-1:0] SlotLast = SlotW'(KERNEL_SIZE - 1);

  conv_state_e state_q, state_d;

  logic [XW-1:0]    x_q, x_d, y_q, y_d;
  logic [PhW-1:0]   px_q, px_d, py_q, py_d;
  logic [CiW-1:0]   ci_q, ci_d;
  logic [ChW-1:0]   co_q, co_d;
  logic [OutW-1:0]  ox_q, ox_d, oy_q, oy_d;
  logic [SlotW-1:0] slot_q, slot_d;
  logic [LatW-1:0]  lat_q, lat_d;

  logic [KERNEL_SIZE-1:0] wr_en_q, wr_en_d, rd_en_q, rd_en_d;
  logic mac_en_q, mac_en_d, acc_clr_q, acc_clr_d, acc_last_q, acc_last_d, pad_q, pad_d;
  logic [OutW-1:0] lx_q, lx_d, ly_q, ly_d;
  logic [ChW-1:0]  lc_q, lc_d;

  logic accept, win, row_valid, border;
  logic [PipeW-1:0] pipe_out;

  assign accept    = (state_q == StRun) && !stall_i;
  assign win       = accept && (x_q >= KLast) && (y_q >= KLast) && (px_q == '0) && (py_q == '0);
  assign row_valid = (y_q >= KLast) && (py_q == '0);

`ifdef CONV_PAD_EN
  localparam logic [XW-1:0] PadLo     = XW'(PadEff);
  localparam logic [XW-1:0] PadHiLast = XW'(PadEff + IFM_SIZE - 1);
  assign border = (x_q < PadLo) || (x_q > PadHiLast) || (y_q < PadLo) || (y_q > PadHiLast);
`else
  assign border = 1'b0;
`endif

  // FSM state register
  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) state_q <= StIdle;
    else        state_q <= state_d;
  end

  // FSM next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:   if (start_i) state_d = StRun;
      StRun:    if (accept && (x_q == ScanLast)) state_d = StRowEnd;
      StRowEnd: state_d = (y_q == ScanLast) ? StChEnd : StRun;
      StChEnd:  state_d = (ci_q == CiLast) ? StFltEnd : StRun;
      StFltEnd: state_d = (co_q == CoLast) ? StDrain : StRun;
      StDrain:  if (lat_q == LatLast) state_d = StDone;
      StDone:   state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  // FSM outputs
  always_comb begin
    busy_o = (state_q != StIdle);
    done_o = (state_q == StDone);
  end

  // Scan, stride-phase and output-coordinate counters
  always_comb begin
    x_d    = x_q;
    y_d    = y_q;
    px_d   = px_q;
    py_d   = py_q;
    ci_d   = ci_q;
    co_d   = co_q;
    ox_d   = ox_q;
    oy_d   = oy_q;
    slot_d = slot_q;
    lat_d  = lat_q;
    case (state_q)
      StRun: begin
        if (accept) begin
          if (x_q == ScanLast) begin
            x_d  = '0;
            px_d = '0;
            ox_d = '0;
          end else begin
            x_d = x_q + 1'b1;
            // Phase stays 0 until the first window column, then cycles through STRIDE.
            px_d = ((x_q < KLast) || (px_q == PhLast)) ? '0 : px_q + 1'b1;
            if (win) ox_d = ox_q + 1'b1;
          end
        end
      end
      StRowEnd: begin
        if (y_q == ScanLast) begin
          y_d    = '0;
          py_d   = '0;
          oy_d   = '0;
          slot_d = '0;
        end else begin
          y_d    = y_q + 1'b1;
          py_d   = ((y_q < KLast) || (py_q == PhLast)) ? '0 : py_q + 1'b1;
          slot_d = (slot_q == SlotLast) ? '0 : slot_q + 1'b1;
          if (row_valid) oy_d = oy_q + 1'b1;
        end
      end
      StChEnd:  ci_d  = (ci_q == CiLast) ? '0 : ci_q + 1'b1;
      StFltEnd: co_d  = (co_q == CoLast) ? '0 : co_q + 1'b1;
      StDrain:  lat_d = (lat_q == LatLast) ? '0 : lat_q + 1'b1;
      default: ;
    endcase
  end

  // Per-pixel controls, registered so they describe the pixel accepted last cycle
  always_comb begin
    wr_en_d    = accept ? (KERNEL_SIZE'(1) << slot_q) : '0;
    rd_en_d    = win ? '1 : '0;
    mac_en_d   = win;
    acc_clr_d  = win && (ci_q == '0);
    acc_last_d = win && (ci_q == CiLast);
    pad_d      = accept && border;
    lx_d       = acc_last_d ? ox_q : '0;
    ly_d       = acc_last_d ? oy_q : '0;
    lc_d       = acc_last_d ? co_q : '0;
  end

  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      x_q        <= '0;
      y_q        <= '0;
      px_q       <= '0;
      py_q       <= '0;
      ci_q       <= '0;
      co_q       <= '0;
      ox_q       <= '0;
      oy_q       <= '0;
      slot_q     <= '0;
      lat_q      <= '0;
      wr_en_q    <= '0;
      rd_en_q    <= '0;
      mac_en_q   <= 1'b0;
      acc_clr_q  <= 1'b0;
      acc_last_q <= 1'b0;
      pad_q      <= 1'b0;
      lx_q       <= '0;
      ly_q       <= '0;
      lc_q       <= '0;
    end else begin
      x_q        <= x_d;
      y_q        <= y_d;
      px_q       <= px_d;
      py_q       <= py_d;
      ci_q       <= ci_d;
      co_q       <= co_d;
      ox_q       <= ox_d;
      oy_q       <= oy_d;
      slot_q     <= slot_d;
      lat_q      <= lat_d;
      wr_en_q    <= wr_en_d;
      rd_en_q    <= rd_en_d;
      mac_en_q   <= mac_en_d;
      acc_clr_q  <= acc_clr_d;
      acc_last_q <= acc_last_d;
      pad_q      <= pad_d;
      lx_q       <= lx_d;
      ly_q       <= ly_d;
      lc_q       <= lc_d;
    end
  end

  assign wr_en_o    = wr_en_q;
  assign rd_en_o    = rd_en_q;
  assign mac_en_o   = mac_en_q;
  assign acc_clr_o  = acc_clr_q;
  assign acc_last_o = acc_last_q;
  assign pad_zero_o = pad_q;

  conv_out_pipe #(
    .Depth(MAC_LAT),
    .Width(PipeW)
  ) u_out_pipe (
    .clk1  (clk1),
    .rst_n (rst_n),
    .d_i   ({acc_last_q, lx_q, ly_q, lc_q}),
    .q_o   (pipe_out)
  );

  assign {out_valid_o, out_x_o, out_y_o, out_c_o} = pipe_out;

endmodule
